// File: rtl/inst_axi_rd_pkg.sv
// inst_axi_rd_pkg: AXI constants and FSM state encoding for the instruction read master
package inst_axi_rd_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    DONE = 3'd4
  } state_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/inst_axi_rd.sv
// inst_axi_rd: AXI4 read master fetching an 8-byte instruction pair as a two-beat burst
module inst_axi_rd
  import inst_axi_rd_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  input  logic        flush,
  output logic [63:0] inst_sram_rdata,
  output logic        inst_rvalid,
  output logic        inst_rerr,
  output logic        stall_req,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  state_t state, state_nxt;
  logic drop, err;
  logic [31:0] addr;
  logic unused;
  assign unused = ^{rid, rlast, inst_sram_addr[2:0]};
  assign arid = 4'd0;
  assign arlen = 8'd1;
  assign arsize = SIZE_4B;
  assign arburst = BURST_INCR;
  assign araddr = addr;
  // next state and handshake outputs; a flush in DONE masks the result that same cycle
  always_comb begin
    state_nxt = state;
    arvalid = 1'b0;
    rready = 1'b0;
    inst_rvalid = 1'b0;
    inst_rerr = 1'b0;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        stall_req = inst_sram_en;
        state_nxt = inst_sram_en ? AR : IDLE;
      end
      AR: begin
        arvalid = 1'b1;
        stall_req = 1'b1;
        state_nxt = arready ? RD0 : AR;
      end
      RD0: begin
        rready = 1'b1;
        stall_req = 1'b1;
        state_nxt = rvalid ? RD1 : RD0;
      end
      RD1: begin
        rready = 1'b1;
        stall_req = 1'b1;
        state_nxt = rvalid ? DONE : RD1;
      end
      DONE: begin
        inst_rvalid = ~drop & ~flush;
        inst_rerr = err & ~drop & ~flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  end
  // request latch, drop/error flags and 64-bit pair assembly
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr <= 32'd0;
      drop <= 1'b0;
      err <= 1'b0;
      inst_sram_rdata <= 64'd0;
    end else begin
      if (state == IDLE && inst_sram_en) begin
        addr <= {inst_sram_addr[31:3], 3'b000};
        drop <= 1'b0;
        err <= 1'b0;
      end
      if ((state == AR || state == RD0 || state == RD1) && flush) drop <= 1'b1;
      if (state == RD0 && rvalid) begin
        inst_sram_rdata[31:0] <= rdata;
        err <= err | (rresp != RESP_OKAY);
      end
      if (state == RD1 && rvalid) begin
        inst_sram_rdata[63:32] <= rdata;
        err <= err | (rresp != RESP_OKAY);
      end
    end
  end
endmodule

// File: tb/tb_inst_axi_rd.sv
// tb_inst_axi_rd: table-driven fetch transactions with a scoreboard of expected results
module tb_inst_axi_rd;
  logic clk = 1'b0, resetn = 1'b0, inst_sram_en = 1'b0, flush = 1'b0;
  logic arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] inst_sram_addr = '0, rdata = '0;
  logic [3:0] rid = '0;
  logic [1:0] rresp = '0;
  logic [63:0] inst_sram_rdata;
  logic inst_rvalid, inst_rerr, stall_req, arvalid, rready;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [63:0] data; logic err; int at;} exp_t;
  // fl: 0 none, 1 flush in AR, 2 flush in RD0, 3 flush with en in IDLE, 4 flush in DONE
  typedef struct {logic [31:0] addr; logic [31:0] d0; logic [31:0] d1; logic [1:0] r0; logic [1:0] r1; int w; int fl;} vec_t;
  exp_t sb[$];
  vec_t v[10];

  inst_axi_rd dut (
    .clk(clk), .resetn(resetn), .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .flush(flush), .inst_sram_rdata(inst_sram_rdata), .inst_rvalid(inst_rvalid), .inst_rerr(inst_rerr),
    .stall_req(stall_req), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn && inst_rvalid) begin
      if (sb.size() == 0) chk("unexpected_inst_rvalid", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("inst_sram_rdata", inst_sram_rdata, e.data);
        chk("inst_rerr", {63'd0, inst_rerr}, {63'd0, e.err});
        chk("latency_cycle", cyc, e.at);
      end
    end
  end

  task automatic run(input vec_t t);
    exp_t e;
    logic [31:0] a;
    a = t.addr & 32'hFFFF_FFF8;
    inst_sram_en = 1'b1;
    inst_sram_addr = t.addr;
    flush = (t.fl == 3);
    #1;
    chk("stall_idle_en", {63'd0, stall_req}, 64'd1);
    e.data = {t.d1, t.d0};
    e.err = (t.r0 != 2'b00) | (t.r1 != 2'b00);
    e.at = cyc + 4 + t.w;
    if (t.fl == 0 || t.fl == 3) sb.push_back(e);
    @(posedge clk); #1;
    inst_sram_en = 1'b0;
    inst_sram_addr = 32'hFFFF_FFFF;
    flush = (t.fl == 1);
    arready = (t.w == 0);
    for (int i = 0; i <= t.w; i++) begin
      #1;
      chk("arvalid", {63'd0, arvalid}, 64'd1);
      chk("araddr", {32'd0, araddr}, {32'd0, a});
      chk("stall_ar", {63'd0, stall_req}, 64'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      arready = (i + 1 == t.w);
    end
    chk("arlen_arsize_arburst_arid", {44'd0, arlen, arsize, arburst, arid}, {44'd0, 8'd1, 3'b010, 2'b01, 4'd0});
    flush = (t.fl == 2);
    rvalid = 1'b1; rdata = t.d0; rresp = t.r0; rlast = 1'b0;
    #1;
    chk("rready_rd0", {63'd0, rready}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    rdata = t.d1; rresp = t.r1; rlast = 1'b1;
    #1;
    chk("rready_rd1", {63'd0, rready}, 64'd1);
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    flush = (t.fl == 4);
    #1;
    chk("done_inst_rvalid", {63'd0, inst_rvalid}, {63'd0, (t.fl == 0 || t.fl == 3)});
    chk("done_stall", {63'd0, stall_req}, 64'd0);
    chk("done_no_ar", {62'd0, arvalid, rready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("idle_stall", {63'd0, stall_req}, 64'd0);
  endtask

  initial begin
    v[0] = '{32'hBFC00004, 32'h11111111, 32'h22222222, 2'b00, 2'b00, 0, 0};
    v[1] = '{32'h80001234, 32'h33333333, 32'h44444444, 2'b00, 2'b00, 3, 0};
    v[2] = '{32'h00001000, 32'h55555555, 32'h66666666, 2'b00, 2'b00, 0, 2};
    v[3] = '{32'h00002000, 32'h77777777, 32'h88888888, 2'b00, 2'b10, 0, 0};
    v[4] = '{32'h00000000, 32'h0A0A0A0A, 32'h0B0B0B0B, 2'b00, 2'b00, 0, 0};
    v[5] = '{32'h00000008, 32'h0C0C0C0C, 32'h0D0D0D0D, 2'b00, 2'b00, 0, 0};
    v[6] = '{32'h00003003, 32'h01010101, 32'h02020202, 2'b01, 2'b00, 1, 3};
    v[7] = '{32'h0000400C, 32'h03030303, 32'h04040404, 2'b00, 2'b00, 2, 1};
    v[8] = '{32'h00005000, 32'h05050505, 32'h06060606, 2'b00, 2'b00, 0, 4};
    v[9] = '{32'h0000600F, 32'hCAFEF00D, 32'hDEADBEEF, 2'b00, 2'b00, 1, 0};
    #2;
    chk("reset_outputs", {58'd0, arvalid, rready, inst_rvalid, inst_rerr, stall_req, 1'b0}, 64'd0);
    chk("reset_rdata", inst_sram_rdata, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    inst_sram_en = 1'b1; #1;
    chk("post_reset_stall_en", {63'd0, stall_req}, 64'd1);
    inst_sram_en = 1'b0; #1;
    chk("post_reset_stall_noen", {63'd0, stall_req}, 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; #1;
    chk("idle_flush_no_effect", {62'd0, arvalid, stall_req}, 64'd0);
    for (int i = 0; i < 10; i++) run(v[i]);
    chk("rdata_hold", inst_sram_rdata, {v[9].d1, v[9].d0});
    rvalid = 1'b1; rdata = 32'h12345678; #1;
    chk("stray_rvalid_rready", {63'd0, rready}, 64'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("stray_rvalid_rdata", inst_sram_rdata, {v[9].d1, v[9].d0});
    inst_sram_en = 1'b1; inst_sram_addr = 32'h00007000;
    @(posedge clk); #1;
    inst_sram_en = 1'b0; arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    rdata = 32'hBBBBBBBB; rlast = 1'b1;
    #1;
    chk("rd1_before_reset_rready", {63'd0, rready}, 64'd1);
    resetn = 1'b0; #1;
    chk("midreset_outputs", {58'd0, arvalid, rready, inst_rvalid, inst_rerr, stall_req, 1'b0}, 64'd0);
    chk("midreset_rdata", inst_sram_rdata, 64'd0);
    chk("midreset_araddr", {32'd0, araddr}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1; #1;
    chk("after_reset_rready", {63'd0, rready}, 64'd0);
    @(posedge clk); #1;
    chk("after_reset_stray", {62'd0, rready, inst_rvalid}, 64'd0);
    chk("after_reset_rdata", inst_sram_rdata, 64'd0);
    rvalid = 1'b0; rlast = 1'b0;
    run(v[0]);
    @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
